// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch initiator.
// Owns the program counter and issues strobe/ack fetches to instruction memory.
// Returned words go to decode over a valid/ready handshake.
// Branch/jump redirects reload the PC. Fatal fetch errors are flagged and sticky.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that waits too long for ack.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_addr,
    output logic        o_stb,
    input  logic        i_ack,
    input  logic [31:0] i_data,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

    // Reject parameter values the fetch logic cannot honour.
    if (RESET_PC[1:0] != 2'b00) begin : g_badResetPc
        $error("instr_fetch: RESET_PC must be 4-byte aligned");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
        $error("instr_fetch: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_opc;
    logic        r_valid;
    logic        r_err;
    logic [1:0]  r_errCode;

    logic        w_redirOk;
    logic        w_redirBad;
    logic        w_timeout;

    // Redirects are decoded once; a misaligned target is a fatal error, not a jump.
    assign w_redirOk  = i_redirect && (i_redirect_pc[1:0] == 2'b00);
    assign w_redirBad = i_redirect && (i_redirect_pc[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_toCnt;

    // The fetch is abandoned on the wait cycle that would bring the count up to the limit.
    assign w_timeout = (r_state == S_REQ) && !i_ack && !i_redirect
                       && ((r_toCnt + 8'd1) == TO_LIMIT);

    // Count consecutive un-acked request cycles; anything else restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toCnt <= 8'd0;
        end else if ((r_state == S_REQ) && !i_ack && !i_redirect) begin
            r_toCnt <= r_toCnt + 8'd1;
        end else begin
            r_toCnt <= 8'd0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Fetch sequencer: redirect outranks ack and ready, and the error state is terminal until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_opc     <= 32'd0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= ERR_NONE;
        end else if (r_state == S_ERR) begin
            r_valid <= 1'b0;
        end else if (w_redirBad) begin
            r_state   <= S_ERR;
            r_valid   <= 1'b0;
            r_err     <= 1'b1;
            r_errCode <= ERR_MISALIGN;
        end else if (w_redirOk) begin
            r_state <= S_REQ;
            r_pc    <= i_redirect_pc;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (i_ack) begin
                        r_instr <= i_data;
                        r_opc   <= r_pc;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end else if (w_timeout) begin
                        r_state   <= S_ERR;
                        r_err     <= 1'b1;
                        r_errCode <= ERR_TIMEOUT;
                    end
                end
                S_VALID: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    // Memory-side request is decoded straight from the state; the address is parked at zero once in error.
    always_comb begin
        o_stb  = (r_state == S_REQ);
        o_addr = (r_state == S_ERR) ? 32'd0 : r_pc;
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_opc;
    assign o_valid    = r_valid;
    assign o_err      = r_err;
    assign o_err_code = r_errCode;

endmodule
